// File: rtl/md_pkg.sv
// Shared definitions for the md load/store path: access sizes, FSM states
// and the default data-memory depth.
package md_pkg;

  // Default data-memory depth in 32-bit words.
  localparam int MEM_WORDS_DEF = 512;

  // Access size encodings as carried on req_size.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Load/store sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/md_lanes.sv
// Byte-lane logic for a little-endian 32-bit word: sub-word extraction with
// sign/zero extension, store merge into an existing word, and alignment check.
module md_lanes
  import md_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o,
  output logic        align_err_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] wdata_rep;
  logic [3:0]  byte_en;

  // Pick the addressed lane, extend it, and replicate store data across lanes.
  always_comb begin
    byte_sel = 8'h00;
    case (lane_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];

    load_o    = word_i;
    wdata_rep = wdata_i;
    case (size_i)
      SZ_B: begin
        load_o    = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
        wdata_rep = {4{wdata_i[7:0]}};
      end
      SZ_H: begin
        load_o    = {{16{~unsigned_i & half_sel[15]}}, half_sel};
        wdata_rep = {2{wdata_i[15:0]}};
      end
      default: begin
        load_o    = word_i;
        wdata_rep = wdata_i;
      end
    endcase

    // Size 11 is illegal; halfwords need an even address, words a 4-aligned one.
    align_err_o = (size_i == 2'b11) ||
                  ((size_i == SZ_H) && lane_i[0]) ||
                  ((size_i == SZ_W) && (lane_i != 2'b00));
  end

  // Per byte: take replicated store data where the access covers the lane.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign byte_en[gi] = ((size_i == SZ_B) && (lane_i == LANE)) ||
                         ((size_i == SZ_H) && (lane_i[1] == LANE[1])) ||
                         (size_i == SZ_W);
    assign merged_o[8*gi +: 8] = byte_en[gi] ? wdata_rep[8*gi +: 8]
                                             : word_i[8*gi +: 8];
  end

endmodule

// File: rtl/md_lsu.sv
// Load/store initiator: turns byte-addressed loads/stores into word accesses
// on a memory that writes on negedge, doing read-modify-write for sub-words.
module md_lsu
  import md_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] AM,
  output logic [31:0] DM_,
  output logic        EW,
  input  logic [31:0] DM
);

  state_e      state_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;
  logic        ew_q;
  logic [IDX_W-1:0] am_q;
  logic [31:0] dm_w_q;

  // Request fields held for the duration of the access.
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;

  logic [1:0]  lane_d;
  logic [1:0]  size_d;
  logic [31:0] load_d;
  logic [31:0] merged_d;
  logic        align_err;
  logic        range_err;
  logic        req_err;

  // In IDLE the lane block checks the incoming request; afterwards it works
  // on the latched request against the word read back from memory.
  always_comb begin
    lane_d    = (state_q == ST_IDLE) ? req_addr[1:0] : lane_q;
    size_d    = (state_q == ST_IDLE) ? req_size      : size_q;
    range_err = (req_addr[31:2] >= 30'(MEM_WORDS));
    req_err   = align_err || range_err;
  end

  md_lanes u_lanes (
    .word_i      (DM),
    .lane_i      (lane_d),
    .size_i      (size_d),
    .unsigned_i  (uns_q),
    .wdata_i     (wdata_q),
    .load_o      (load_d),
    .merged_o    (merged_d),
    .align_err_o (align_err)
  );

  // Sequencer with every output registered so the memory sees stable AM/DM_/EW.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      ew_q         <= 1'b0;
      am_q         <= '0;
      dm_w_q       <= 32'h0;
      we_q         <= 1'b0;
      size_q       <= SZ_B;
      uns_q        <= 1'b0;
      lane_q       <= 2'b00;
      wdata_q      <= 32'h0;
    end else begin
      resp_valid_q <= 1'b0;
      ew_q         <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q         <= req_we;
            size_q       <= req_size;
            uns_q        <= req_unsigned;
            lane_q       <= req_addr[1:0];
            wdata_q      <= req_wdata;
            req_ready_q  <= 1'b0;
            resp_rdata_q <= 32'h0;
            if (req_err) begin
              // Rejected requests never touch AM or EW.
              resp_err_q   <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= ST_RESP;
            end else begin
              resp_err_q <= 1'b0;
              am_q       <= req_addr[IDX_W+1:2];
              if (req_we && (req_size == SZ_W)) begin
                dm_w_q  <= req_wdata;
                ew_q    <= 1'b1;
                state_q <= ST_WRITE;
              end else begin
                state_q <= ST_READ;
              end
            end
          end
        end
        ST_READ: begin
          if (we_q) begin
            dm_w_q  <= merged_d;
            ew_q    <= 1'b1;
            state_q <= ST_WRITE;
          end else begin
            resp_rdata_q <= load_d;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end
        end
        ST_WRITE: begin
          resp_rdata_q <= 32'h0;
          resp_valid_q <= 1'b1;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          resp_rdata_q <= 32'h0;
          resp_err_q   <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default: begin
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign EW         = ew_q;
  assign AM         = {{(32-IDX_W){1'b0}}, am_q};
  assign DM_        = dm_w_q;

endmodule

// File: tb/tb_md_lsu.sv
// Directed bench for md_lsu with a negedge-write word memory model.
module tb_md_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] AM;
  logic [31:0] DM_;
  logic        EW;
  logic [31:0] DM;

  int tests = 0;
  int fails = 0;
  int ew_count = 0;
  int ew_snap;
  logic preload = 1'b1;
  logic [31:0] mem [512];

  always #5 clk = ~clk;

  md_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .AM(AM), .DM_(DM_), .EW(EW), .DM(DM)
  );

  assign DM = mem[AM[8:0]];

  always @(negedge clk) begin
    if (preload) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
      mem[8] <= 32'h11223344;
    end else if (EW) begin
      mem[AM[8:0]] <= DM_;
    end
    if (EW) ew_count <= ew_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request, let it be accepted, and leave the bench in cycle 1.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    $display("[TB] req we=%0d size=%0d uns=%0d addr=%08h wdata=%08h", we, sz, uns, addr, wd);
  endtask

  // Load with 2-cycle latency.
  task automatic load(input string tag, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] exp);
    issue(1'b0, sz, uns, addr, 32'h0);
    chk({tag, "_c1_valid"}, {31'h0, resp_valid}, 32'h0);
    step();
    chk({tag, "_valid"}, {31'h0, resp_valid}, 32'h1);
    chk({tag, "_rdata"}, resp_rdata, exp);
    chk({tag, "_err"}, {31'h0, resp_err}, 32'h0);
    step();
  endtask

  // Request that must be rejected: response in cycle 1, ready again in cycle 2.
  task automatic reject(input string tag, input logic we, input logic [1:0] sz,
                        input logic [31:0] addr);
    ew_snap = ew_count;
    issue(we, sz, 1'b0, addr, 32'hFFFF_FFFF);
    chk({tag, "_valid"}, {31'h0, resp_valid}, 32'h1);
    chk({tag, "_err"}, {31'h0, resp_err}, 32'h1);
    chk({tag, "_rdata"}, resp_rdata, 32'h0);
    chk({tag, "_ew"}, {31'h0, EW}, 32'h0);
    step();
    chk({tag, "_ready_c2"}, {31'h0, req_ready}, 32'h1);
    chk({tag, "_valid_c2"}, {31'h0, resp_valid}, 32'h0);
    chk({tag, "_ew_count"}, 32'(ew_count - ew_snap), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    step(); step();
    preload = 1'b0;
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", {31'h0, resp_err}, 32'h0);
    chk("rst_ew", {31'h0, EW}, 32'h0);
    chk("rst_am", AM, 32'h0);
    chk("rst_dmw", DM_, 32'h0);
    rst_n = 1'b1;
    step();

    // SW 0x10 <- DEADBEEF
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("sw_c1_ew", {31'h0, EW}, 32'h1);
    chk("sw_c1_am", AM, 32'h4);
    chk("sw_c1_dmw", DM_, 32'hDEADBEEF);
    chk("sw_c1_ready", {31'h0, req_ready}, 32'h0);
    chk("sw_c1_valid", {31'h0, resp_valid}, 32'h0);
    step();
    chk("sw_c2_valid", {31'h0, resp_valid}, 32'h1);
    chk("sw_c2_err", {31'h0, resp_err}, 32'h0);
    chk("sw_c2_rdata", resp_rdata, 32'h0);
    chk("sw_c2_ew", {31'h0, EW}, 32'h0);
    chk("sw_mem4", mem[4], 32'hDEADBEEF);
    step();
    chk("sw_c3_ready", {31'h0, req_ready}, 32'h1);

    // Byte loads, signed and unsigned; no writes
    ew_snap = ew_count;
    load("lb_13", 2'b00, 1'b0, 32'h13, 32'hFFFFFFDE);
    load("lbu_13", 2'b00, 1'b1, 32'h13, 32'h000000DE);
    load("lb_10", 2'b00, 1'b0, 32'h10, 32'hFFFFFFEF);
    load("lw_10", 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("loads_ew_count", 32'(ew_count - ew_snap), 32'h0);

    // SH 0x12 <- 1234 (read-modify-write)
    ew_snap = ew_count;
    issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234);
    chk("sh_c1_ew", {31'h0, EW}, 32'h0);
    chk("sh_c1_valid", {31'h0, resp_valid}, 32'h0);
    step();
    chk("sh_c2_ew", {31'h0, EW}, 32'h1);
    chk("sh_c2_dmw", DM_, 32'h1234BEEF);
    chk("sh_c2_am", AM, 32'h4);
    chk("sh_c2_valid", {31'h0, resp_valid}, 32'h0);
    step();
    chk("sh_c3_valid", {31'h0, resp_valid}, 32'h1);
    chk("sh_c3_ew", {31'h0, EW}, 32'h0);
    chk("sh_mem4", mem[4], 32'h1234BEEF);
    chk("sh_ew_count", 32'(ew_count - ew_snap), 32'h1);
    step();
    load("lhu_10", 2'b01, 1'b1, 32'h10, 32'h0000BEEF);
    load("lh_10", 2'b01, 1'b0, 32'h10, 32'hFFFFBEEF);
    load("lh_12", 2'b01, 1'b0, 32'h12, 32'h00001234);

    // SB 0x11 <- xx5A
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF5A);
    step();
    chk("sb_c2_dmw", DM_, 32'h12345AEF);
    step(); step();
    chk("sb_mem4", mem[4], 32'h12345AEF);

    // Rejections
    reject("lw_mis", 1'b0, 2'b10, 32'h11);
    reject("sh_mis", 1'b1, 2'b01, 32'h13);
    reject("size11", 1'b0, 2'b11, 32'h0);
    reject("sw_oor", 1'b1, 2'b10, 32'h800);
    chk("oor_am_held", AM, 32'h4);

    // Last in-range word
    issue(1'b1, 2'b10, 1'b0, 32'h7FC, 32'hCAFEF00D);
    chk("sw_last_am", AM, 32'h1FF);
    step();
    chk("sw_last_err", {31'h0, resp_err}, 32'h0);
    chk("sw_last_mem", mem[511], 32'hCAFEF00D);
    step();

    // Reset during READ of a sub-word store
    ew_snap = ew_count;
    issue(1'b1, 2'b00, 1'b0, 32'h20, 32'h000000AA);
    chk("rmid_am", AM, 32'h8);
    rst_n = 1'b0;
    step();
    chk("rmid_ready", {31'h0, req_ready}, 32'h1);
    chk("rmid_valid", {31'h0, resp_valid}, 32'h0);
    chk("rmid_ew", {31'h0, EW}, 32'h0);
    chk("rmid_am0", AM, 32'h0);
    chk("rmid_dmw", DM_, 32'h0);
    rst_n = 1'b1;
    step();
    chk("rmid_ready2", {31'h0, req_ready}, 32'h1);
    chk("rmid_valid2", {31'h0, resp_valid}, 32'h0);
    step();
    chk("rmid_mem8", mem[8], 32'h11223344);
    chk("rmid_ew_count", 32'(ew_count - ew_snap), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/md_lsu.md
Name: md_lsu

Overview:
- Load/store initiator that sits between the datapath memory stage and the word-organised data memory (ports AM, DM_, EW, DM).
- Converts byte-addressed MIPS loads and stores (LB/LBU/LH/LHU/LW/SB/SH/SW) into word accesses, using a valid/ready request and a one-shot response.
- Sub-word stores are done as read-modify-write.
- Misaligned and out-of-range accesses are rejected before they reach memory.

Parameters:
- MEM_WORDS, 512: depth of the data memory in 32-bit words; any word index at or above this is out of range.
- IDX_W, 9: width of the word index, equal to clog2(MEM_WORDS).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word; 11 is illegal and returns an error.
- req_unsigned  in  1  zero-extend on loads (LBU/LHU); ignored for stores and words.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle pulse when the access completes.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or illegal size; valid with resp_valid.
- AM  out  32  memory word index, zero-extended from IDX_W.
- DM_  out  32  memory write data.
- EW  out  1  memory write enable; memory writes on negedge while high.
- DM  in  32  memory read data, combinational from AM.

Behaviour:
- Reset values (rst_n low at posedge): state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; EW=0; AM=0; DM_=0.
- Registered outputs: all outputs are registered, so EW, AM and DM_ are stable for a full cycle around the memory negedge.
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch we, size, unsigned, addr and wdata; compute idx=addr[IDX_W+1:2] and lane=addr[1:0].
  - An error is any of: size==11; halfword with addr[0]=1; word with addr[1:0]!=0; addr[31:2] >= MEM_WORDS.
  - On error: go to RESP with err=1. AM and EW are never driven for that request.
  - Otherwise: a load or a sub-word store goes to READ; a word store goes to WRITE.
  - AM=idx is loaded on the accept edge.
- READ: one cycle; sample DM at the end of the cycle.
  - Load: extract the lane, sign- or zero-extend, then go to RESP.
  - Sub-word store: merge wdata into the sampled word, DM_=merged, then go to WRITE.
- WRITE:
  - EW=1 for exactly this one cycle; AM and DM_ held constant.
  - Next state RESP; EW=0 on exit.
- RESP:
  - resp_valid=1 for exactly one cycle, with resp_rdata and resp_err.
  - Next state IDLE. No request is accepted in RESP.
- Lane mapping: little-endian. Byte lane k is DM[8k+7:8k]; halfword lane 0 is [15:0] and lane 2 is [31:16].
- Latency (accept edge = cycle 0; resp_valid high during the cycle shown):
  - Error: cycle 1.
  - Load or word store: cycle 2.
  - Sub-word store: cycle 3.
- Throughput: one request per latency+1 cycles.
- EW is asserted only in WRITE. Loads and errors never assert EW.
- Reset mid-operation: any state returns to IDLE. If rst_n is low at the posedge that would enter WRITE, EW stays 0 and memory is unchanged. A pending response is dropped.

Decomposition:
- Shared package md_pkg:
  - size encodings (SZ_B, SZ_H, SZ_W);
  - state enum (ST_IDLE, ST_READ, ST_WRITE, ST_RESP);
  - default MEM_WORDS.
- Sub-module md_lanes: combinational block taking word, lane, size, unsigned and wdata. It produces the extended load value, the merged store word and the alignment error. It is shared with the future instruction-fetch path.

Test Plan:
- Word store: SW addr 0x10, wdata 0xDEADBEEF.
  - Cycle 1: EW=1, AM=4, DM_=0xDEADBEEF.
  - Cycle 2: resp_valid=1, err=0; mem[4]=0xDEADBEEF.
- Signed vs unsigned byte load: LB addr 0x13 → resp_rdata 0xFFFFFFDE. LBU addr 0x13 → 0x000000DE. EW stays 0 throughout.
- Sub-word store: SH addr 0x12, wdata 0x00001234 on mem[4]=0xDEADBEEF.
  - READ in cycle 1; EW only in cycle 2 with DM_=0x1234BEEF; resp in cycle 3.
  - Then LHU addr 0x10 → 0x0000BEEF.
- Misalignment: LW addr 0x11 → resp_valid with err=1 in cycle 1, rdata 0, EW never high. SH addr 0x13 → same.
- Out of range: SW addr 0x800 (idx 512) → err=1, EW never high; req_ready returns high in cycle 2.
- Reset mid-operation: SB addr 0x20 accepted, rst_n low during the READ cycle → no EW, mem[8] unchanged, all outputs at reset values, req_ready=1 next cycle.
